// File: rtl/ysyx_22050518_div_pkg.sv
// Shared types and constant helpers for the ysyx_22050518 iterative divider.
package ysyx_22050518_div_pkg;

    localparam int DIV_MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic int div_cnt_width(input int xlen);
        return $clog2(xlen);
    endfunction

    // Most negative n-bit two's-complement value, right-aligned in DIV_MAX_W bits.
    function automatic logic [DIV_MAX_W-1:0] div_min_pattern(input int n);
        return DIV_MAX_W'(1'b1) << (n - 1);
    endfunction

    function automatic logic [DIV_MAX_W-1:0] div_ones_pattern(input int n);
        return {DIV_MAX_W{1'b1}} >> (DIV_MAX_W - n);
    endfunction

endpackage

// File: rtl/ysyx_22050518_cond_neg.sv
// Conditional two's-complement negation: used for operand magnitude and result sign fix-up.
module ysyx_22050518_cond_neg #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_in,
    input  logic         i_neg,
    output logic [W-1:0] o_out
);

    assign o_out = i_neg ? ({W{1'b0}} - i_in) : i_in;

endmodule

// File: rtl/ysyx_22050518_div_gen.sv
// Iterative restoring divider with valid/ready handshakes, RISC-V special-case fast path
// and word-mode (DIVW/REMW family) sign extension of results.
module ysyx_22050518_div_gen
    import ysyx_22050518_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            op_signed,
    input  logic            op_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = div_cnt_width(XLEN);

    localparam logic [DIV_MAX_W-1:0] MIN_FULL_W  = div_min_pattern(XLEN);
    localparam logic [DIV_MAX_W-1:0] MIN_HALF_W  = div_min_pattern(HALF);
    localparam logic [DIV_MAX_W-1:0] ONES_FULL_W = div_ones_pattern(XLEN);
    localparam logic [DIV_MAX_W-1:0] ONES_HALF_W = div_ones_pattern(HALF);
    localparam logic [XLEN-1:0]      MIN_FULL    = MIN_FULL_W[XLEN-1:0];
    localparam logic [HALF-1:0]      MIN_HALF    = MIN_HALF_W[HALF-1:0];
    localparam logic [XLEN-1:0]      ONES_FULL   = ONES_FULL_W[XLEN-1:0];
    localparam logic [HALF-1:0]      ONES_HALF   = ONES_HALF_W[HALF-1:0];
    localparam logic [CW-1:0]        CNT_FULL    = CW'(XLEN - 1);
    localparam logic [CW-1:0]        CNT_HALF    = CW'(HALF - 1);

    div_state_e      r_state;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_remd;
    logic [CW-1:0]   r_cnt;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_word;

    logic            w_accept;
    logic [XLEN-1:0] w_a_wsx;
    logic [XLEN-1:0] w_b_wsx;
    logic            w_a_sign;
    logic            w_b_sign;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN-1:0] w_a_init;
    logic [XLEN-1:0] w_b_init;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_sp_q;
    logic [XLEN-1:0] w_sp_r;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_q_next;
    logic [XLEN-1:0] w_q_neg;
    logic [XLEN-1:0] w_r_neg;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_remd;
    assign w_accept  = in_valid && (r_state == IDLE) && !flush;

    // In word mode the low HALF bits are the operand; bit HALF-1 is its sign.
    assign w_a_wsx  = {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]};
    assign w_b_wsx  = {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]};
    assign w_a_sign = op_signed && (op_word ? dividend[HALF-1] : dividend[XLEN-1]);
    assign w_b_sign = op_signed && (op_word ? divisor[HALF-1] : divisor[XLEN-1]);
    assign w_a_ext  = op_word ? w_a_wsx : dividend;
    assign w_b_ext  = op_word ? w_b_wsx : divisor;

    ysyx_22050518_cond_neg #(.W(XLEN)) u_abs_a (.i_in(w_a_ext), .i_neg(w_a_sign), .o_out(w_a_abs));
    ysyx_22050518_cond_neg #(.W(XLEN)) u_abs_b (.i_in(w_b_ext), .i_neg(w_b_sign), .o_out(w_b_abs));

    // Word dividend is pre-aligned to the MSB so iteration always consumes r_a[XLEN-1].
    assign w_a_init = op_word ? {w_a_abs[HALF-1:0], {HALF{1'b0}}} : w_a_abs;
    assign w_b_init = op_word ? {{HALF{1'b0}}, w_b_abs[HALF-1:0]} : w_b_abs;

    assign w_b_zero  = op_word ? (divisor[HALF-1:0] == {HALF{1'b0}}) : (divisor == {XLEN{1'b0}});
    assign w_ovf     = op_signed && (op_word ?
                       ((dividend[HALF-1:0] == MIN_HALF) && (divisor[HALF-1:0] == ONES_HALF)) :
                       ((dividend == MIN_FULL) && (divisor == ONES_FULL)));
    assign w_special = w_b_zero || w_ovf;
    assign w_sp_q    = w_b_zero ? ONES_FULL : w_a_ext;
    assign w_sp_r    = w_b_zero ? w_a_ext : {XLEN{1'b0}};

    // One restoring-division step: subtract divisor from the shifted partial remainder.
    always_comb begin
        w_shift = {r_rem, r_a[XLEN-1]};
        w_trial = w_shift - {1'b0, r_b};
        if (w_trial[XLEN]) begin
            w_rem_next = w_shift[XLEN-1:0];
            w_q_next   = {r_q[XLEN-2:0], 1'b0};
        end else begin
            w_rem_next = w_trial[XLEN-1:0];
            w_q_next   = {r_q[XLEN-2:0], 1'b1};
        end
    end

    ysyx_22050518_cond_neg #(.W(XLEN)) u_fix_q (.i_in(r_q),   .i_neg(r_qneg), .o_out(w_q_neg));
    ysyx_22050518_cond_neg #(.W(XLEN)) u_fix_r (.i_in(r_rem), .i_neg(r_rneg), .o_out(w_r_neg));

    assign w_q_fix = r_word ? {{HALF{w_q_neg[HALF-1]}}, w_q_neg[HALF-1:0]} : w_q_neg;
    assign w_r_fix = r_word ? {{HALF{w_r_neg[HALF-1]}}, w_r_neg[HALF-1:0]} : w_r_neg;

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= {XLEN{1'b0}};
            r_b     <= {XLEN{1'b0}};
            r_q     <= {XLEN{1'b0}};
            r_rem   <= {XLEN{1'b0}};
            r_quot  <= {XLEN{1'b0}};
            r_remd  <= {XLEN{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_word  <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_special) begin
                            r_quot  <= w_sp_q;
                            r_remd  <= w_sp_r;
                            r_state <= DONE;
                        end else begin
                            r_a     <= w_a_init;
                            r_b     <= w_b_init;
                            r_q     <= {XLEN{1'b0}};
                            r_rem   <= {XLEN{1'b0}};
                            r_qneg  <= w_a_sign ^ w_b_sign;
                            r_rneg  <= w_a_sign;
                            r_word  <= op_word;
                            r_cnt   <= op_word ? CNT_HALF : CNT_FULL;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_a   <= {r_a[XLEN-2:0], 1'b0};
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1'b1);
                    end
                end
                FIX: begin
                    r_quot  <= w_q_fix;
                    r_remd  <= w_r_fix;
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_div_gen.sv
// Directed self-checking bench for ysyx_22050518_div_gen (XLEN=64).
module tb_ysyx_22050518_div_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        op_signed;
    logic        op_word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        w;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    ysyx_22050518_div_gen #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .op_signed(op_signed), .op_word(op_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // Issue one operation; lat counts cycles from the accept cycle to the first out_valid cycle.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                         output int lat, output logic [63:0] q, output logic [63:0] r);
        @(negedge clk);
        dividend = a; divisor = b; op_signed = s; op_word = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
        end
    endtask

    task automatic consume(output logic ir, output logic ov);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ir = in_ready;
        ov = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 4;
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (quotient !== 64'd0)  begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
        if (remainder !== 64'd0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    endtask

    // Runs a table of vectors; comparisons are inline per feature task below.
    task automatic test_arith();
        vec_t v[5];
        int lat; logic [63:0] q, r; logic ir, ov;
        v[0] = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 66};
        v[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        v[2] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
        v[3] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        v[4] = '{64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0, 64'hC000_0000_0000_0000, 64'd0, 66};
        for (int i = 0; i < 5; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, v[i].w, lat, q, r);
            consume(ir, ov);
            checks += 5;
            if (q !== v[i].q)     begin errors++; $display("FAIL arith[%0d]_q: got %h want %h", i, q, v[i].q); end
            if (r !== v[i].r)     begin errors++; $display("FAIL arith[%0d]_r: got %h want %h", i, r, v[i].r); end
            if (lat !== v[i].lat) begin errors++; $display("FAIL arith[%0d]_lat: got %0d want %0d", i, lat, v[i].lat); end
            if (ir !== 1'b1)      begin errors++; $display("FAIL arith[%0d]_ready_after: got %b want 1", i, ir); end
            if (ov !== 1'b0)      begin errors++; $display("FAIL arith[%0d]_valid_after: got %b want 0", i, ov); end
        end
    endtask

    task automatic test_special();
        vec_t v[2];
        int lat; logic [63:0] q, r; logic ir, ov;
        v[0] = '{64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1};
        v[1] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1};
        for (int i = 0; i < 2; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, v[i].w, lat, q, r);
            consume(ir, ov);
            checks += 4;
            if (q !== v[i].q)     begin errors++; $display("FAIL special[%0d]_q: got %h want %h", i, q, v[i].q); end
            if (r !== v[i].r)     begin errors++; $display("FAIL special[%0d]_r: got %h want %h", i, r, v[i].r); end
            if (lat !== v[i].lat) begin errors++; $display("FAIL special[%0d]_lat: got %0d want %0d", i, lat, v[i].lat); end
            if (ir !== 1'b1)      begin errors++; $display("FAIL special[%0d]_ready_after: got %b want 1", i, ir); end
        end
    endtask

    task automatic test_word();
        vec_t v[4];
        int lat; logic [63:0] q, r; logic ir, ov;
        v[0] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        v[1] = '{64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 34};
        v[2] = '{64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        v[3] = '{64'h1234_5678_8000_0007, 64'hABCD_0000_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0007, 1};
        for (int i = 0; i < 4; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, v[i].w, lat, q, r);
            consume(ir, ov);
            checks += 3;
            if (q !== v[i].q)     begin errors++; $display("FAIL word[%0d]_q: got %h want %h", i, q, v[i].q); end
            if (r !== v[i].r)     begin errors++; $display("FAIL word[%0d]_r: got %h want %h", i, r, v[i].r); end
            if (lat !== v[i].lat) begin errors++; $display("FAIL word[%0d]_lat: got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_flush();
        int lat; int seen; logic [63:0] q, r; logic ir, ov;
        @(negedge clk);
        dividend = 64'd1000; divisor = 64'd3; op_signed = 1'b0; op_word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_result: out_valid cycles=%0d want 0", seen); end
        // flush together with in_valid must not accept
        @(negedge clk);
        dividend = 64'd9; divisor = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_same_cycle: in_ready got %b want 1", in_ready); end
        do_op(64'd9, 64'd3, 1'b0, 1'b0, lat, q, r);
        consume(ir, ov);
        checks += 3;
        if (q !== 64'd3)  begin errors++; $display("FAIL after_flush_q: got %h want 3", q); end
        if (r !== 64'd0)  begin errors++; $display("FAIL after_flush_r: got %h want 0", r); end
        if (lat !== 66)   begin errors++; $display("FAIL after_flush_lat: got %0d want 66", lat); end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] q, r; logic ir, ov;
        do_op(64'd1234567, 64'd1000, 1'b0, 1'b0, lat, q, r);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks += 4;
            if (out_valid !== 1'b1)       begin errors++; $display("FAIL bp[%0d]_out_valid: got %b want 1", i, out_valid); end
            if (in_ready !== 1'b0)        begin errors++; $display("FAIL bp[%0d]_in_ready: got %b want 0", i, in_ready); end
            if (quotient !== 64'd1234)    begin errors++; $display("FAIL bp[%0d]_q: got %h want %h", i, quotient, 64'd1234); end
            if (remainder !== 64'd567)    begin errors++; $display("FAIL bp[%0d]_r: got %h want %h", i, remainder, 64'd567); end
        end
        consume(ir, ov);
        checks += 2;
        if (ir !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", ir); end
        if (ov !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", ov); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] q, r; logic ir, ov;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, lat, q, r);
        consume(ir, ov);
        checks += 2;
        if (q !== 64'h0FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b2b0_q: got %h want 0fffffffffffffff", q); end
        if (r !== 64'hF)                   begin errors++; $display("FAIL b2b0_r: got %h want f", r); end
        do_op(64'd77, 64'd77, 1'b1, 1'b0, lat, q, r);
        consume(ir, ov);
        checks += 3;
        if (q !== 64'd1) begin errors++; $display("FAIL b2b1_q: got %h want 1", q); end
        if (r !== 64'd0) begin errors++; $display("FAIL b2b1_r: got %h want 0", r); end
        if (lat !== 66)  begin errors++; $display("FAIL b2b1_lat: got %0d want 66", lat); end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        dividend = 64'd500; divisor = 64'd9; op_signed = 1'b0; op_word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 4;
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        if (quotient !== 64'd0)  begin errors++; $display("FAIL midrst_quotient: got %h want 0", quotient); end
        if (remainder !== 64'd0) begin errors++; $display("FAIL midrst_remainder: got %h want 0", remainder); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = 64'd0; divisor = 64'd0; op_signed = 1'b0; op_word = 1'b0;
        test_reset();
        test_arith();
        test_special();
        test_word();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050518_div_gen.md
# ysyx_22050518_div_gen

Parametrised iterative restoring divider for the ysyx_22050518 RV64 execute stage. It generalises the fixed 64-bit divider in four ways: operand width is a parameter, it uses valid/ready handshakes on both sides (output backpressure), it resolves the RISC-V divide-by-zero and signed-overflow cases in a fast path, and half-width (word) results are sign-extended per DIVW/DIVUW/REMW/REMUW. It sits beside the multiplier as a multi-cycle functional unit and is killed by the pipeline flush.

## Interface
- XLEN, 64, operand/result width; even, ≥ 8.
- HALF, XLEN/2, width used when op_word=1 (derived; do not override).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill in-flight operation; synchronous.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; = (state==IDLE).
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- op_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- op_word  in  1  1 = operate on low HALF bits, sign-extend results.
- out_valid  out  1  result valid; = (state==DONE).
- out_ready  in  1  consumer accepts result.
- quotient  out  XLEN  registered quotient.
- remainder  out  XLEN  registered remainder.

## Operation
- Accept = in_valid && in_ready && !flush. Operands and op bits captured on accept; inputs ignored otherwise.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: on accept, if special case → DONE with results loaded; else → CALC, cnt = N−1 (N = op_word ? HALF : XLEN).
  - CALC: one quotient bit per cycle; cnt decrements; at cnt==0 → FIX.
  - FIX: conditional negation of quotient/remainder, word sign-extension, load outputs → DONE.
  - DONE: out_valid=1; on out_ready → IDLE.
- Operand prep (at accept): effective operands are low N bits; signed mode takes |x| using bit N−1 as sign. Record q_neg = sign(a)^sign(b), r_neg = sign(a) (signed mode only).
- Iteration: remainder register N+1 bits, quotient shift register N bits. Each cycle: trial = {rem[N−1:0], a_msb} − {0,b}; if trial ≥ 0 keep trial and shift in 1, else keep shifted value and shift in 0.
- Special cases (effective N-bit operands):
  - divisor==0: quotient = all ones, remainder = dividend (N bits, sign-extended if op_word).
  - op_signed && dividend==MIN_N && divisor==−1: quotient = dividend, remainder = 0.
- Word mode: results computed in HALF bits, bit HALF−1 replicated into upper bits for both signed and unsigned ops.
- flush (any state) or rst: next state IDLE, no result delivered, out_valid low next cycle. flush in same cycle as in_valid: not accepted.
- quotient/remainder hold their value outside FIX/special-case load; reset to 0.

## Timing
- Reset values: state IDLE, in_ready=1 after reset cycle, out_valid=0, quotient=0, remainder=0.
- Normal latency: accept in cycle T, CALC T+1..T+N, FIX T+N+1, out_valid from T+N+2 (66 for XLEN=64, 34 word mode).
- Special-case latency: out_valid at T+1.
- out_valid held, outputs stable, until out_ready; result handshake in cycle D → in_ready at D+1 (no same-cycle re-accept).
- One operation in flight; no pipelining.

## Structure
- Package ysyx_22050518_div_pkg: state enum (IDLE/CALC/FIX/DONE), counter width function clog2(XLEN), MIN/all-ones constant helpers.
- Sub-module ysyx_22050518_cond_neg (parameter W; in, neg → neg ? −in : in): used for operand absolute value and result sign fix-up.
- Top holds FSM, counter, iteration datapath, special-case detect.

## Test plan
- Unsigned 100 / 7, XLEN=64 → quotient 14, remainder 2, out_valid exactly 66 cycles after accept.
- Signed −7 / 2 → quotient −3 (0xFFFF…FFFD), remainder −1; signed 7 / −2 → −3, 1.
- Divide by zero 5 / 0 unsigned → quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, out_valid at T+1; signed 0x8000_0000_0000_0000 / −1 → quotient 0x8000_0000_0000_0000, remainder 0 at T+1.
- Word: DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF_FFFF_FFFF → quotient 0xFFFF_FFFF_8000_0000, remainder 0 (fast path); DIVUW 0x0000_0000_FFFF_FFFE / 1 → quotient 0xFFFF_FFFF_FFFF_FFFE, latency 34.
- Flush at CALC cycle 10 → out_valid never asserts, in_ready=1 next cycle; immediately issued 9 / 3 returns 3, 0.
- Backpressure: out_ready low for 5 cycles after out_valid → outputs and out_valid stable, in_ready low; result consumed on out_ready, in_ready next cycle. Randomised sweep vs. reference model for XLEN=64 and XLEN=32.
